// File: rtl/ap_mult_pipe.sv
// Three-stage streaming approximate multiplier: OR-compressed low columns below k_eff,
// exact carry-save reduction (Baugh-Wooley in signed mode) for the remaining columns.
module ap_mult_pipe #(
  parameter int N     = 8,
  parameter int K_MAX = 6,
  parameter int KW    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  input  logic            is_signed,
  input  logic [KW-1:0]   k_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  res,
  output logic [KW-1:0]   res_k
);

  localparam int W = 2 * N;
  localparam logic [KW-1:0] K_MAX_L = KW'(K_MAX);

  logic            en;
  logic [KW-1:0]   k_eff;

  logic [N-1:0]    a_s1_reg, b_s1_reg;
  logic            sgn_s1_reg, v_s1_reg;
  logic [KW-1:0]   k_s1_reg;

  logic [N-1:0]    pp_bits [N];
  logic [W-1:0]    pp_row  [N];
  logic [W-1:0]    const_row, exact_mask;
  logic [W-1:0]    sum_next, carry_next, approx_next;

  logic [W-1:0]    sum_s2_reg, carry_s2_reg, approx_s2_reg;
  logic [KW-1:0]   k_s2_reg;
  logic            v_s2_reg;

  // The whole pipeline advances together; a stalled output freezes every stage.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign k_eff    = (k_sel > K_MAX_L) ? K_MAX_L : k_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_s1_reg   <= 1'b0;
      a_s1_reg   <= '0;
      b_s1_reg   <= '0;
      sgn_s1_reg <= 1'b0;
      k_s1_reg   <= '0;
    end else if (en) begin
      v_s1_reg   <= in_valid;
      a_s1_reg   <= a;
      b_s1_reg   <= b;
      sgn_s1_reg <= is_signed;
      k_s1_reg   <= k_eff;
    end
  end

  // Row gi holds a[gj] & b[gi] at column gi+gj; Baugh-Wooley flips terms touching one sign bit.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      localparam bit FLIP = ((gi == N - 1) != (gj == N - 1));
      assign pp_bits[gi][gj] = (a_s1_reg[gj] & b_s1_reg[gi]) ^ (sgn_s1_reg & FLIP);
    end
    assign pp_row[gi] = W'(pp_bits[gi]) << gi;
  end

  assign const_row  = sgn_s1_reg ? ((W'(1) << N) | (W'(1) << (W - 1))) : '0;
  assign exact_mask = {W{1'b1}} << k_s1_reg;

  function automatic logic [2*W-1:0] csa(input logic [W-1:0] s, input logic [W-1:0] c,
                                         input logic [W-1:0] x);
    return {s ^ c ^ x, ((s & c) | (s & x) | (c & x)) << 1};
  endfunction

  // Masked rows feed a carry-save chain, so carries only ever move upward from column k_eff.
  always_comb begin
    sum_next    = '0;
    carry_next  = '0;
    approx_next = '0;
    for (int r = 0; r < N; r++) begin
      approx_next = approx_next | (pp_row[r] & ~exact_mask);
      {sum_next, carry_next} = csa(sum_next, carry_next, pp_row[r] & exact_mask);
    end
    {sum_next, carry_next} = csa(sum_next, carry_next, const_row);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_s2_reg      <= 1'b0;
      sum_s2_reg    <= '0;
      carry_s2_reg  <= '0;
      approx_s2_reg <= '0;
      k_s2_reg      <= '0;
    end else if (en) begin
      v_s2_reg      <= v_s1_reg;
      sum_s2_reg    <= sum_next;
      carry_s2_reg  <= carry_next;
      approx_s2_reg <= approx_next;
      k_s2_reg      <= k_s1_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res       <= '0;
      res_k     <= '0;
    end else if (en) begin
      out_valid <= v_s2_reg;
      res       <= (sum_s2_reg + carry_s2_reg) | approx_s2_reg;
      res_k     <= k_s2_reg;
    end
  end

endmodule

// File: doc/ap_mult_pipe.md
Name: ap_mult_pipe

Overview:
- Parametrised, pipelined approximate multiplier: N x N operands, signed (Baugh-Wooley) or unsigned, selectable per transaction.
- The approximation depth k is selected at runtime per transaction. Columns below k use carry-free OR compression; columns at or above k are compressed exactly.
- Successor to the fixed 8-bit combinational compressor. Adds width/depth generics, runtime accuracy and sign control, and a valid/ready streaming interface for the accelerator datapath.

Parameters:
- N, 8, operand width (4..32).
- K_MAX, 6, maximum approximate column count; must satisfy K_MAX <= N.
- KW, 3, width of k_sel; 2^KW > K_MAX.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  N  multiplicand.
- b  input  N  multiplier.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- k_sel  input  KW  requested approximate column count.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- res  output  2N  product (exact or approximate).
- res_k  output  KW  effective k used for this result.

Behaviour:
- Reset (async assert, sync release): all stage valids 0; out_valid=0; res=0; res_k=0; in_ready=1 after release.
- Global advance: en = !out_valid | out_ready; in_ready = en (combinational from out_valid/out_ready only, never from in_valid).
- Beat accepted when in_valid & in_ready. The three-stage pipeline shifts only when en=1. Bubbles are not collapsed.
- S1 registers a, b, is_signed, k_eff and valid.
  - k_eff = min(k_sel, K_MAX), computed before registering.
- S2 generates partial products pp[i][j] = a[j] & b[i], placed in column i+j.
  - Signed mode: invert pp where exactly one of i, j equals N-1.
  - Signed mode: add constant 1 in column N and column 2N-1.
  - Reduce all columns >= k_eff exactly to one sum row and one carry row, registered.
  - Columns j < k_eff: approx bit j = OR of every pp bit in column j. No carry is produced into or out of this region.
  - Constants are never in the approximate region (K_MAX <= N).
- S3 computes res = {sum row + carry row over columns >= k_eff, approx bits [k_eff-1:0]}, truncated to 2N bits, and registers it with res_k and out_valid.
- Latency: exactly 3 clk edges from acceptance to out_valid, with no stalls.
- Throughput: 1 beat per cycle while out_ready=1.
- k_eff=0 gives bit-exact a*b (signed or unsigned, mod 2^2N).
- Stall: out_valid & !out_ready freezes every stage register.
  - res and res_k hold stable until the handshake completes.
  - Invalid beats behind the output also freeze. A bubble in S1 or S2 is not compressed.
- Output handshake and a new input in the same cycle: both occur; the pipeline shifts.
- Reset mid-operation: all in-flight beats are discarded; no out_valid follows.
- Per-beat mode: is_signed and k_sel travel with their beat. Consecutive beats may differ.

Test Plan:
- Exact unsigned, N=8, k_sel=0: a=200, b=100 -> res=0x4E20 after 3 cycles, res_k=0. Then a=255, b=255 -> res=0xFE01.
- Exact signed, k_sel=0: a=0xFD(-3), b=0x05 -> res=0xFFF1. Then a=0x80, b=0x80 -> res=0x4000.
- Approximate, unsigned, k_sel=4: a=0x0F, b=0x0F -> res=0x00BF (exact 0xE1), res_k=4. Then k_sel=7 -> clamped: res_k=6.
- Back-to-back mixed stream: 4 beats (k=0 unsigned, k=4 unsigned, k=0 signed, k=2 signed) on consecutive cycles with out_ready=1 -> 4 results on consecutive cycles, in order, each matching the reference model.
- Backpressure: out_ready=0, issue beats continuously -> exactly 3 accepted, then in_ready=0. res stable while stalled. Raise out_ready -> in_ready=1 the same cycle, results drain in order, none lost or duplicated.
- Reset: assert rst_n=0 with 2 beats in flight -> out_valid=0 and res=0 immediately. After release, no stale result appears. The next beat has latency 3.
